// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - single-clock ADC sample FIFO with write-time left-justification
// Optional sticky overflow flag enabled by defining ADC_FIFO_OVF_STICKY_EN.
module adc_capture_fifo #(
  parameter int DATA_W    = 14,
  parameter int OUT_W     = 16,
  parameter int ADDR_W    = 13,
  parameter int AFULL_LVL = (1 << ADDR_W) - 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [1:0]        bw_bits,
  input  logic              ovf_clr,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W+1)'(AFULL_LVL);

  logic [OUT_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic              ovf_q, ovf_d, rd_arm_q, rd_arm_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic [OUT_W-1:0]  wdata;
  int                shamt;
  logic              rd_acc, wr_acc, wr_drop;

  always_comb begin
    // Shifting the zero-extended word left by (OUT_W - R) both discards din bits above R and pads the LSBs.
    shamt   = OUT_W - 8 - 2 * int'(bw_bits);
    wdata   = OUT_W'(din) << shamt;

    rd_acc  = rd_en && !empty_q && rd_arm_q;
    wr_acc  = wr_en && (!full_q || rd_acc);
    wr_drop = wr_en && !wr_acc;

    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_acc;
    rd_arm_d     = 1'b1;

    if (wr_acc) wptr_d = wptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rptr_d = rptr_q + ADDR_W'(1);
      dout_d = mem[rptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    afull_d = (count_d >= CNT_AFULL);

`ifdef ADC_FIFO_OVF_STICKY_EN
    if (wr_drop)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
`else
    ovf_d = 1'b0;
`endif
  end

`ifndef ADC_FIFO_OVF_STICKY_EN
  logic ovf_inputs_unused;
  assign ovf_inputs_unused = ovf_clr ^ wr_drop;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      ovf_q        <= 1'b0;
      rd_arm_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      ovf_q        <= ovf_d;
      rd_arm_q     <= rd_arm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_adc_capture_fifo.sv
// tb/tb_adc_capture_fifo.sv - scoreboard bench for adc_capture_fifo against a queue reference model
// Overflow expectations follow ADC_FIFO_OVF_STICKY_EN.
module tb_adc_capture_fifo;

  localparam int DEPTH = 8192;
  localparam int AFULL = DEPTH - 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  bw_bits = '0;
  logic        ovf_clr = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [13:0] count;
  logic        overflow;

  adc_capture_fifo dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .bw_bits(bw_bits), .ovf_clr(ovf_clr), .dout(dout), .dout_valid(dout_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] model_q [$];
  logic [15:0] exp_q [$];
  bit          armed = 1'b0;
  bit          m_ovf = 1'b0;

  function automatic logic [15:0] justify(int d, int bw);
    int r = 8 + 2 * bw;
    return 16'((d & ((1 << r) - 1)) << (16 - r));
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("count", int'(count), model_q.size());
    check("full", int'(full), int'(model_q.size() == DEPTH));
    check("empty", int'(empty), int'(model_q.size() == 0));
    check("almost_full", int'(almost_full), int'(model_q.size() >= AFULL));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic cycle(bit wr, bit rd, int d, int bw, bit clr);
    bit          rd_ok, wr_ok;
    logic [15:0] pend;
    wr_en = wr; rd_en = rd; din = 14'(d); bw_bits = 2'(bw); ovf_clr = clr;
    rd_ok = rd && model_q.size() > 0 && armed;
    wr_ok = wr && (model_q.size() < DEPTH || rd_ok);
    pend  = '0;
    if (rd_ok) pend = model_q.pop_front();
    if (wr_ok) model_q.push_back(justify(d, bw));
`ifdef ADC_FIFO_OVF_STICKY_EN
    if (wr && !wr_ok) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
`endif
    armed = 1'b1;
    @(posedge clk);
    if (rd_ok) exp_q.push_back(pend);
    #1;
    check_flags();
  endtask

  task automatic do_reset(int low_cycles);
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    model_q.delete();
    m_ovf = 1'b0;
    armed = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected word per dout_valid pulse; dout must hold between pulses.
  logic [15:0] exp_dout = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_dout = '0;
      end else begin
        check("dout_valid", int'(dout_valid), int'(exp_q.size() > 0));
        if (dout_valid && exp_q.size() > 0) exp_dout = exp_q.pop_front();
        check("dout", int'(dout), int'(exp_dout));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    do_reset(3);
    repeat (5) cycle(0, 1, 0, 0, 0);

    cycle(1, 0, 'h3ABC, 2, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 'h01FF, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom), $urandom_range(0, 3), 1'b0);

    do_reset(1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, i, 3, 0);
    cycle(1, 0, 'h123, 3, 0);
    cycle(1, 0, 'h5, 3, 1);
    cycle(0, 0, 0, 3, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 'h155, 1, 0);
    cycle(0, 0, 0, 0, 0);

    while (model_q.size() < DEPTH)
      cycle(1'b1, $urandom_range(0, 3) == 0, int'($urandom), $urandom_range(0, 3), 1'b0);
    for (int i = 0; i < 100; i++)
      cycle(1, 1, int'($urandom), $urandom_range(0, 3), 0);
    while (model_q.size() > 500) cycle(0, 1, 0, 0, 0);

    do_reset(1);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 'h2AAA, 3, 0);
    cycle(0, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    while (model_q.size() > 0) cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
